// File: rtl/deadlock_report_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : deadlock_report_arbiter_if
// Description : Detect-unit fabric and report handshake bundle for the
//               deadlock report arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface deadlock_report_arbiter_if #(
    parameter int PROC_NUM = 2,
    parameter int PW       = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
);
    logic [PROC_NUM-1:0] dl_in_vec;
    logic                dl_detect_out;
    logic [PROC_NUM-1:0] origin;
    logic                token_clear;
    logic                report_valid;
    logic                report_ready;
    logic [PW-1:0]       report_proc;
    logic [15:0]         scan_count;

    modport master (
        input  dl_in_vec,
        input  report_ready,
        output dl_detect_out,
        output origin,
        output token_clear,
        output report_valid,
        output report_proc,
        output scan_count
    );

    modport slave (
        output dl_in_vec,
        output report_ready,
        input  dl_detect_out,
        input  origin,
        input  token_clear,
        input  report_valid,
        input  report_proc,
        input  scan_count
    );
endinterface
`default_nettype wire

// File: rtl/deadlock_report_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : deadlock_report_arbiter
// Description : Round-robin token origin arbiter that confirms returned tokens
//               as a deadlock and reports it over a valid/ready handshake.
//               Optional macro DEADLOCK_REPORT_DISPLAY_EN adds sim messages.
// Revision    : 1.0 - initial release
// ============================================================================
module deadlock_report_arbiter #(
    parameter int PROC_NUM       = 2,
    parameter int SCAN_CYCLES    = 8,
    parameter int CONFIRM_CYCLES = 4
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    deadlock_report_arbiter_if.master  bus
);

    localparam int c_PTR_W = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;
    localparam int c_WIN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int c_CNF_W = $clog2(CONFIRM_CYCLES + 1);

    localparam logic [c_PTR_W-1:0]  c_PTR_LAST = c_PTR_W'(PROC_NUM - 1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_WIN_W-1:0]  c_WIN_LAST = c_WIN_W'(SCAN_CYCLES - 1);
    localparam logic [c_WIN_W-1:0]  c_WIN_ONE  = c_WIN_W'(1);
    localparam logic [c_CNF_W-1:0]  c_CNF_LAST = c_CNF_W'(CONFIRM_CYCLES - 1);
    localparam logic [c_CNF_W-1:0]  c_CNF_ONE  = c_CNF_W'(1);
    localparam logic [PROC_NUM-1:0] c_ORG_ONE  = PROC_NUM'(1);

    typedef enum logic [2:0] {
        S_CLEAR    = 3'd0,
        S_SCAN     = 3'd1,
        S_CONFIRM  = 3'd2,
        S_DETECTED = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_PTR_W-1:0]  r_ptr;
    logic [c_PTR_W-1:0]  w_ptr_nxt;
    logic [c_WIN_W-1:0]  r_win;
    logic [c_WIN_W-1:0]  w_win_nxt;
    logic [c_CNF_W-1:0]  r_cnf;
    logic [c_CNF_W-1:0]  w_cnf_nxt;
    logic [15:0]         r_scan_cnt;
    logic [15:0]         w_scan_cnt_nxt;

    logic                r_dl_detect;
    logic                w_dl_detect_nxt;
    logic [PROC_NUM-1:0] r_origin;
    logic [PROC_NUM-1:0] w_origin_nxt;
    logic                r_token_clear;
    logic                w_token_clear_nxt;
    logic                r_report_valid;
    logic                w_report_valid_nxt;
    logic [c_PTR_W-1:0]  r_report_proc;
    logic [c_PTR_W-1:0]  w_report_proc_nxt;

    logic                w_hit;

    assign w_hit = bus.dl_in_vec[r_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_CLEAR;
            r_ptr          <= '0;
            r_win          <= '0;
            r_cnf          <= '0;
            r_scan_cnt     <= '0;
            r_dl_detect    <= 1'b0;
            r_origin       <= '0;
            r_token_clear  <= 1'b0;
            r_report_valid <= 1'b0;
            r_report_proc  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_ptr          <= w_ptr_nxt;
            r_win          <= w_win_nxt;
            r_cnf          <= w_cnf_nxt;
            r_scan_cnt     <= w_scan_cnt_nxt;
            r_dl_detect    <= w_dl_detect_nxt;
            r_origin       <= w_origin_nxt;
            r_token_clear  <= w_token_clear_nxt;
            r_report_valid <= w_report_valid_nxt;
            r_report_proc  <= w_report_proc_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_win_nxt         = r_win;
        w_cnf_nxt         = r_cnf;
        w_scan_cnt_nxt    = r_scan_cnt;
        w_report_proc_nxt = r_report_proc;

        case (r_state)
            S_CLEAR: begin
                // Out of reset the clear pulse has not been shown yet, so
                // CLEAR is held one extra edge to emit it.
                w_win_nxt = '0;
                if (r_token_clear) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_hit) begin
                    w_cnf_nxt   = c_CNF_ONE;
                    w_state_nxt = (CONFIRM_CYCLES == 1) ? S_DETECTED : S_CONFIRM;
                end else if (r_win == c_WIN_LAST) begin
                    w_state_nxt = S_CLEAR;
                    w_ptr_nxt   = (r_ptr == c_PTR_LAST) ? '0 : r_ptr + c_PTR_ONE;
                    if (r_scan_cnt != 16'hFFFF) begin
                        w_scan_cnt_nxt = r_scan_cnt + 16'd1;
                    end
                end else begin
                    w_win_nxt = r_win + c_WIN_ONE;
                end
            end
            S_CONFIRM: begin
                if (!w_hit) begin
                    w_state_nxt = S_CLEAR;
                end else begin
                    w_cnf_nxt = r_cnf + c_CNF_ONE;
                    if (r_cnf == c_CNF_LAST) begin
                        w_state_nxt = S_DETECTED;
                    end
                end
            end
            S_DETECTED: begin
                if (r_report_valid && bus.report_ready) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase

        // Outputs are registered from the state being entered so they line up
        // with the state the block is in during the following cycle.
        w_token_clear_nxt  = (w_state_nxt == S_CLEAR);
        w_origin_nxt       = (w_state_nxt == S_CLEAR) ? '0 : (c_ORG_ONE << w_ptr_nxt);
        w_report_valid_nxt = (w_state_nxt == S_DETECTED);
        w_dl_detect_nxt    = r_dl_detect | (w_state_nxt == S_DETECTED);
        if (w_state_nxt == S_DETECTED) begin
            w_report_proc_nxt = w_ptr_nxt;
        end
    end

    assign bus.dl_detect_out = r_dl_detect;
    assign bus.origin        = r_origin;
    assign bus.token_clear   = r_token_clear;
    assign bus.report_valid  = r_report_valid;
    assign bus.report_proc   = r_report_proc;
    assign bus.scan_count    = r_scan_cnt;

`ifdef DEADLOCK_REPORT_DISPLAY_EN
    always @(posedge clock) begin
        if (reset) begin
            if ((r_state != S_DETECTED) && (w_state_nxt == S_DETECTED)) begin
                $display("ERROR: deadlock detected, origin process %0d at %0t",
                         w_ptr_nxt, $time);
            end
            if ((r_state == S_DETECTED) && r_report_valid && bus.report_ready) begin
                $display("deadlock report accepted");
                $finish;
            end
        end
    end
`else
    // Silent build: the surrounding testbench decides when to stop.
`endif

endmodule
`default_nettype wire
